// File: rtl/shiftreg_univ_p.sv
// rtl/shiftreg_univ_p.sv - parametrised universal shift register with shift-by-N sequencer (optional SHREG_ABORT_EN)
module shiftreg_univ_p #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             lin,
    input  logic             rin,
`ifdef SHREG_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lmode;
    logic             abort_req;

`ifdef SHREG_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // One single-bit operation; reserved and hold codes fall through to the current value.
    function automatic logic [WIDTH-1:0] op_next(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             li,
        input logic             ri
    );
        logic [WIDTH-1:0] r;
        case (op)
            3'b001:  r = {li, cur[WIDTH-1:1]};
            3'b010:  r = {cur[WIDTH-2:0], ri};
            3'b011:  r = din;
            3'b100:  r = {cur[0], cur[WIDTH-1:1]};
            3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: r = cur;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            state <= IDLE;
            cnt   <= '0;
            lmode <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == 3'b011) begin
                            q     <= d;
                            state <= DONE;
                        end else if (amt == '0 || mode == 3'b000 || mode == 3'b111) begin
                            state <= DONE;
                        end else begin
                            lmode <= mode;
                            cnt   <= amt;
                            state <= RUN;
                        end
                    end else begin
                        q <= op_next(mode, q, d, lin, rin);
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        // Abandon the sequence with the partial result and no done pulse.
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        q <= op_next(lmode, q, d, lin, rin);
                        if (cnt == CNT_W'(1)) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign so_l = q[WIDTH-1];
    assign so_r = q[0];
    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shiftreg_univ_p.sv
// tb/tb_shiftreg_univ_p.sv - scoreboard bench for shiftreg_univ_p (abort cases under SHREG_ABORT_EN)
module tb_shiftreg_univ_p;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [2:0]   mode = 3'b000;
    logic         start = 1'b0;
    logic [C-1:0] amt = '0;
    logic [W-1:0] d = '0;
    logic         lin = 1'b0;
    logic         rin = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] q;
    logic         so_l, so_r, busy, done;

    shiftreg_univ_p #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .amt(amt),
        .d(d), .lin(lin), .rin(rin),
`ifdef SHREG_ABORT_EN
        .abort(abort),
`endif
        .q(q), .so_l(so_l), .so_r(so_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] eq;
        logic         eb;
        logic         ed;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference: remaining ops of the sequence in flight plus a pending done flag.
    logic [W-1:0] m_q = '0;
    int           m_rem = 0;
    logic [2:0]   m_op = 3'b000;
    logic         m_done = 1'b0;
    bit           abort_on;

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] v,
                                            input logic [W-1:0] dv, input logic li, input logic ri);
        logic [W-1:0] r;
        case (op)
            3'd1:    r = (v >> 1) | (W'(li) << (W - 1));
            3'd2:    r = (v << 1) | W'(ri);
            3'd3:    r = dv;
            3'd4:    r = (v >> 1) | (v << (W - 1));
            3'd5:    r = (v << 1) | (v >> (W - 1));
            3'd6:    r = W'($signed(v) >>> 1);
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_q = '0; m_rem = 0; m_done = 1'b0;
        end else if (m_rem > 0) begin
            if (abort_on && abort) begin
                m_rem = 0;
            end else begin
                m_q = ref_op(m_op, m_q, d, lin, rin);
                m_rem = m_rem - 1;
                m_done = (m_rem == 0);
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (start) begin
            if (mode == 3'd3) begin
                m_q = d; m_done = 1'b1;
            end else if (amt == 0 || mode == 3'd0 || mode == 3'd7) begin
                m_done = 1'b1;
            end else begin
                m_op = mode; m_rem = int'(amt);
            end
        end else begin
            m_q = ref_op(mode, m_q, d, lin, rin);
        end
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e.eq = m_q; e.eb = (m_rem > 0); e.ed = m_done;
        sb.push_back(e);
    endtask

    task automatic expect_q(input logic [W-1:0] exp, input string name);
        checks++;
        if (q !== exp) begin
            errors++;
            $display("FAIL %s: q=%h required %h", name, q, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.eq) begin errors++; $display("FAIL sb_q: q=%h required %h", q, e.eq); end
            checks++;
            if (busy !== e.eb) begin errors++; $display("FAIL sb_busy: busy=%b required %b", busy, e.eb); end
            checks++;
            if (done !== e.ed) begin errors++; $display("FAIL sb_done: done=%b required %b", done, e.ed); end
            checks++;
            if (so_l !== e.eq[W-1] || so_r !== e.eq[0]) begin
                errors++;
                $display("FAIL sb_serial: so_l=%b so_r=%b required %b %b", so_l, so_r, e.eq[W-1], e.eq[0]);
            end
        end
    end

    initial begin
`ifdef SHREG_ABORT_EN
        abort_on = 1'b1;
`else
        abort_on = 1'b0;
`endif
        reset = 1'b1;
        cycle(); cycle();
        expect_q(8'h00, "reset");
        reset = 1'b0; mode = 3'd3; d = 8'hA5;
        cycle(); expect_q(8'hA5, "load");
        mode = 3'd1; lin = 1'b1;
        cycle(); expect_q(8'hD2, "shr_lin1");
        mode = 3'd2; rin = 1'b0;
        cycle(); expect_q(8'hA4, "shl_rin0");

        mode = 3'd3; d = 8'hA5; cycle();
        start = 1'b1; mode = 3'd5; amt = 4'd3; cycle();
        mode = 3'd3; d = 8'h00;
        repeat (3) cycle();
        expect_q(8'h2D, "rotl3");
        cycle();
        start = 1'b0; mode = 3'd0; cycle();

        mode = 3'd3; d = 8'h96; cycle();
        start = 1'b1; mode = 3'd6; amt = 4'd2; cycle();
        start = 1'b0; mode = 3'd0;
        repeat (2) cycle();
        expect_q(8'hE5, "asr2");
        cycle();
        start = 1'b1; mode = 3'd1; amt = 4'd0; cycle();
        start = 1'b0; mode = 3'd0; cycle();
        expect_q(8'hE5, "amt0");

        mode = 3'd3; d = 8'h01; cycle();
        start = 1'b1; mode = 3'd4; amt = 4'd10; cycle();
        start = 1'b0; mode = 3'd0;
        repeat (4) cycle();
        reset = 1'b1; cycle();
        expect_q(8'h00, "reset_mid_seq");
        reset = 1'b0; repeat (2) cycle();

`ifdef SHREG_ABORT_EN
        mode = 3'd3; d = 8'h01; cycle();
        start = 1'b1; mode = 3'd2; rin = 1'b0; amt = 4'd5; cycle();
        start = 1'b0; mode = 3'd0;
        repeat (2) cycle();
        abort = 1'b1; cycle();
        abort = 1'b0;
        expect_q(8'h04, "abort_partial");
        repeat (2) cycle();
`endif

        for (int i = 0; i < 600; i++) begin
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            amt   = C'($urandom_range(0, 15));
            d     = W'($urandom);
            lin   = 1'($urandom);
            rin   = 1'($urandom);
            reset = ($urandom_range(0, 59) == 0);
            abort = abort_on && ($urandom_range(0, 29) == 0);
            cycle();
        end
        reset = 1'b0; abort = 1'b0; start = 1'b0;

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
